sensor_serializer: RTL
======================

# sensor_serializer

Parametrised parallel-to-serial converter for the sensor output path: accepts WIDTH-bit words over a valid/ready handshake and emits them as LANES bits per CLK cycle, gap-free while words keep arriving. With LANES=2 it drives the D0/D1 pair of a DDR output primitive directly; with LANES=1 it drives a plain pin. It replaces the fixed 8→1 multi-clock serializer with a single-clock design that adds buffering, framing, underrun reporting and selectable bit order.

## Interface
- WIDTH, 8: parallel word width; must be a multiple of LANES.
- LANES, 2: bits emitted per cycle; WIDTH/LANES ≥ 2.
- MSB_FIRST, 0: 0 = bit 0 leaves first, 1 = bit WIDTH-1 leaves first.
- IDLE_BIT, 0: line level driven on every lane when no word is being sent.
- CLK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_DATA  in  WIDTH  parallel word.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  block can accept a word.
- OUT  out  LANES  serial beat; OUT[0] is the earlier bit (to DDR D0).
- OUT_VALID  out  1  OUT carries word data, not idle.
- FRAME  out  1  high on the first beat of each word.
- UNDERRUN  out  1  one-cycle pulse when streaming stops for lack of data.

## Operation
- N = WIDTH/LANES beats per word; beat counter 0..N-1, width $clog2(N).
- One-entry holding register (hold_valid) in front of a WIDTH-bit shifter.
- IN_READY = !hold_valid. Transfer on IN_VALID && IN_READY at a rising edge.
- States: IDLE, SHIFT.
  - IDLE: if hold_valid, load shifter from holding, clear hold_valid, beat=0, go SHIFT. Otherwise stay.
  - SHIFT: advance one beat per cycle. On beat N-1:
    - if hold_valid, reload and stay in SHIFT with no gap;
    - else go IDLE and pulse UNDERRUN for one cycle, aligned with the first idle beat.
- A holding register load and a new input transfer in the same cycle are legal. The holding register refills on the cycle after it empties. Since N ≥ 2, full rate is sustained.
- Beat mapping for beat b, lane i:
  - MSB_FIRST=0: OUT[i] = word[b*LANES+i].
  - MSB_FIRST=1: OUT[i] = word[WIDTH-1-(b*LANES+i)].
- Idle output: OUT = {LANES{IDLE_BIT}}, OUT_VALID=0, FRAME=0.
- Reset values: OUT idle pattern, OUT_VALID 0, FRAME 0, UNDERRUN 0, state IDLE, hold_valid 0, so IN_READY is 1.
- Reset asserted mid-word: the in-flight word and the held word are discarded, outputs go idle immediately, and no UNDERRUN is reported.
- The first start from IDLE never counts as an underrun.

## Timing
- All outputs are registered. IN_READY is one gate from a flop.
- Latency from a transfer at edge e0 in IDLE:
  - shifter loads at e1;
  - beat 0 is on OUT between e1 and e2, with FRAME=1 and OUT_VALID=1;
  - beat N-1 is on OUT between eN and eN+1.
- Back-to-back words: the FRAME of word k+1 immediately follows beat N-1 of word k, with no idle beat.
- Underrun: beat N-1 with no held word is followed by the idle pattern and UNDERRUN=1 in the same cycle.

## Configuration
- SENSOR_SER_UNDERRUN_CNT_EN defined:
  - adds output UNDERRUN_CNT (16 bits) and input CNT_CLR (1 bit);
  - the counter increments on each UNDERRUN pulse and saturates at 16'hFFFF;
  - CNT_CLR synchronously clears it and has priority over a simultaneous increment;
  - reset value is 0.
- Macro not defined: both ports and the counter are absent; UNDERRUN behaviour is unchanged.

## Structure
- Package sensor_ser_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT);
  - the UNDERRUN_CNT width constant (16);
  - a helper function for the beat-counter width.
- One sub-module, sensor_ser_hold: the one-entry holding register with valid/ready, parametrised by WIDTH.
- The FSM, shifter and beat mapping live in the top level.

## Test plan
- Reset release, WIDTH=8, LANES=2, MSB_FIRST=0, single word 8'hB4:
  - IN_READY=1 after reset;
  - OUT beats are 2'b00, 2'b01, 2'b11, 2'b10 (OUT[0] first);
  - FRAME on the first beat only;
  - then idle and UNDERRUN pulses once.
- Continuous stream 8'h00, 8'hFF, 8'hA5 with IN_VALID held high:
  - 12 consecutive OUT_VALID beats, no gap;
  - FRAME every 4th beat;
  - no UNDERRUN until after the last word.
- MSB_FIRST=1, LANES=1, word 8'h80 → OUT sequence 1,0,0,0,0,0,0,0.
- Back-pressure: present words continuously while the shifter is busy:
  - IN_READY drops after the holding register fills and reasserts the cycle after each reload;
  - no word is lost or duplicated (scoreboard check).
- Reset asserted during beat 2 with a word held:
  - outputs idle immediately, IN_READY=1, UNDERRUN stays 0;
  - the next word after release starts cleanly with FRAME.
- With SENSOR_SER_UNDERRUN_CNT_EN: three separated single words give UNDERRUN_CNT=3; CNT_CLR coinciding with a pulse gives 0.

Source files
------------

// File: rtl/sensor_ser_pkg.sv
// Shared types and constants for the sensor output serializer.
// The SENSOR_SER_UNDERRUN_CNT_EN build option uses UNDERRUN_CNT_W.
package sensor_ser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  localparam int UNDERRUN_CNT_W = 16;

  // Beat counter width, kept at least one bit wide.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sensor_ser_hold.sv
// One-entry holding register that sits in front of the serializer shifter.
// It accepts a word when empty and is emptied when the shifter takes it.
module sensor_ser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data
);

  assign in_ready = !hold_valid;

  // A take only happens while full and a transfer only while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sensor_serializer.sv
// Parallel-to-serial converter emitting LANES bits per clock with framing and underrun flag.
// Optional SENSOR_SER_UNDERRUN_CNT_EN adds a saturating underrun counter with clear.
module sensor_serializer
  import sensor_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES-1:0]          out,
  output logic                      out_valid,
  output logic                      frame,
  output logic                      underrun
`ifdef SENSOR_SER_UNDERRUN_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

  localparam int N  = WIDTH / LANES;
  localparam int BW = beat_cnt_width(N);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(N - 1);
  localparam logic [LANES-1:0] IDLE_PAT  = {LANES{IDLE_BIT}};

  ser_state_e       state, state_d;
  logic [BW-1:0]    beat, beat_d;
  logic [WIDTH-1:0] shifter, shifter_d;
  logic [LANES-1:0] out_d;
  logic             out_valid_d, frame_d, underrun_d;
  logic             take;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  // The next beat always sits at the leaving end of the shifter.
  function automatic logic [LANES-1:0] first_beat(input logic [WIDTH-1:0] w);
    logic [LANES-1:0] b;
    b = '0;
    for (int i = 0; i < LANES; i++) begin
      b[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << LANES) : (w >> LANES);
  endfunction

  sensor_ser_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .take      (take),
    .hold_valid(hold_valid),
    .hold_data (hold_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      beat      <= '0;
      shifter   <= '0;
      out       <= IDLE_PAT;
      out_valid <= 1'b0;
      frame     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      shifter   <= shifter_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      frame     <= frame_d;
      underrun  <= underrun_d;
    end
  end

  // Outputs are computed one beat ahead so that they leave a register.
  always_comb begin
    state_d     = state;
    beat_d      = beat;
    shifter_d   = shifter;
    out_d       = IDLE_PAT;
    out_valid_d = 1'b0;
    frame_d     = 1'b0;
    underrun_d  = 1'b0;
    take        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_valid) take = 1'b1;
      end
      ST_SHIFT: begin
        if (beat == LAST_BEAT) begin
          if (hold_valid) begin
            take = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          beat_d      = beat + 1'b1;
          out_d       = first_beat(shifter);
          shifter_d   = advance(shifter);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d     = ST_SHIFT;
      beat_d      = '0;
      out_d       = first_beat(hold_data);
      shifter_d   = advance(hold_data);
      out_valid_d = 1'b1;
      frame_d     = 1'b1;
    end
  end

`ifdef SENSOR_SER_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (cnt_clr) begin
      underrun_cnt <= '0;
    end else if (underrun_d && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule
